// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display controller: segment codes,
// register-select encodings and the digit count.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  // Active-low segment codes for g..a (dp excluded), indexed by nibble value.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SEG_ADDR_LO  = 2'b00,
    SEG_ADDR_DP  = 2'b01,
    SEG_ADDR_HI  = 2'b10,
    SEG_ADDR_RSV = 2'b11
  } seg_addr_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder with blank override.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup, forced dark when blanking.
  always_comb begin
    seg = SEG_HEX[nibble];
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_display.sv
// Eight-digit multiplexed seven-segment display controller on the CPU IO bus.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank digits above
// the most significant nonzero nibble of the displayed value.
module seg7_display
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        segcs,
  input  logic        segwrite,
  input  logic [1:0]  segaddr,
  input  logic [15:0] segwdata,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

  logic [31:0] disp_q, disp_d;
  logic [7:0]  dp_mask_q, dp_mask_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  seg_en_q, seg_en_d;
  logic [7:0]  seg_out_q, seg_out_d;

  seg_addr_e   addr;
  logic [3:0]  nibble;
  logic        blank;
  logic [6:0]  seg_code;

  assign addr = seg_addr_e'(segaddr);

  // Register file: value halves and decimal-point mask.
  always_comb begin
    disp_d    = disp_q;
    dp_mask_d = dp_mask_q;
    if (segcs && segwrite) begin
      case (addr)
        SEG_ADDR_LO: disp_d[15:0]  = segwdata;
        SEG_ADDR_HI: disp_d[31:16] = segwdata;
        SEG_ADDR_DP: dp_mask_d     = segwdata[7:0];
        default:     ;
      endcase
    end
  end

  // Refresh divider and active digit index.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [2:0] top_nz;

  // Highest nonzero nibble position; digit 0 stays lit even for a zero value.
  always_comb begin
    top_nz = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if (disp_q[4*i +: 4] != 4'h0) top_nz = 3'(i);
    end
    blank = (idx_q > top_nz);
  end
`else
  assign blank = 1'b0;
`endif

  assign nibble = disp_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg_code)
  );

  // Next output pattern for the currently active digit.
  always_comb begin
    seg_en_d  = ~(8'h01 << idx_q);
    seg_out_d = {~dp_mask_q[idx_q], seg_code};
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      disp_q    <= '0;
      dp_mask_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      seg_en_q  <= '1;
      seg_out_q <= '1;
    end else begin
      disp_q    <= disp_d;
      dp_mask_q <= dp_mask_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign seg_en  = seg_en_q;
  assign seg_out = seg_out_q;

endmodule

// File: tb/tb_seg7_display.sv
// Self-checking bench for seg7_display with a cycle-level behavioural model.
module tb_seg7_display;

  localparam int unsigned SD = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        segcs;
  logic        segwrite;
  logic [1:0]  segaddr;
  logic [15:0] segwdata;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  int checks = 0;
  int errors = 0;

  seg7_display #(.SCAN_DIV(SD)) dut (
    .clock    (clock),
    .reset    (reset),
    .segcs    (segcs),
    .segwrite (segwrite),
    .segaddr  (segaddr),
    .segwdata (segwdata),
    .seg_en   (seg_en),
    .seg_out  (seg_out)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [31:0] m_disp;
  logic [7:0]  m_dp;
  int unsigned m_phase;
  int unsigned m_dig;
  logic [7:0]  exp_en;
  logic [7:0]  exp_out;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] ref_out(input int unsigned digit, input logic [31:0] v,
                                          input logic [7:0] dp);
    logic [7:0] r;
    int unsigned top;
    r = glyph(4'((v >> (4 * digit)) % 16));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    top = 0;
    while (top < 7 && (v >> (4 * (top + 1))) != 0) top++;
    if (digit > top) r = 8'hFF;
`else
    top = 0;
`endif
    r[7] = ~dp[digit];
    return r;
  endfunction

  // Model: output pattern at each edge comes from state before that edge.
  always @(posedge clock) begin
    if (!reset) begin
      exp_en  = 8'hFF;
      exp_out = 8'hFF;
      m_disp  = '0;
      m_dp    = '0;
      m_phase = 0;
    end else begin
      m_dig   = (m_phase / SD) % 8;
      exp_en  = ~(8'h01 << m_dig);
      exp_out = ref_out(m_dig, m_disp, m_dp);
      m_phase++;
      if (segcs && segwrite) begin
        case (segaddr)
          2'b00:   m_disp[15:0]  = segwdata;
          2'b10:   m_disp[31:16] = segwdata;
          2'b01:   m_dp          = segwdata[7:0];
          default: ;
        endcase
      end
    end
  end

  // ---------------- helpers (no checking) ----------------
  function automatic int digit_of(input logic [7:0] en);
    int d;
    d = -1;
    for (int i = 0; i < 8; i++) if (en === ~(8'h01 << i)) d = i;
    return d;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic cs);
    segcs    = cs;
    segwrite = 1'b1;
    segaddr  = a;
    segwdata = d;
    @(negedge clock);
    segwrite = 1'b0;
    segcs    = 1'b0;
  endtask

  task automatic wait_for_en(input logic [7:0] en, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (seg_en === en) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0; segcs = 1'b0; segwrite = 1'b0; segaddr = 2'b00; segwdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (seg_en !== 8'hFF || seg_out !== 8'hFF) begin
        errors++;
        $display("FAIL reset_hold: seg_en=%h seg_out=%h required FF FF", seg_en, seg_out);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (seg_en !== 8'hFE || seg_out !== 8'hC0) begin
        errors++;
        $display("FAIL reset_release[%0d]: seg_en=%h seg_out=%h required FE C0", i, seg_en, seg_out);
      end
    end
    @(negedge clock);
    checks++;
    if (seg_en !== 8'hFD) begin
      errors++;
      $display("FAIL reset_second_digit: seg_en=%h required FD", seg_en);
    end
  endtask

  task automatic test_frame;
    logic [7:0] want [8];
    bit ok;
    want = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hA1, 8'hC6, 8'h83, 8'h88};
    wr(2'b00, 16'h1234, 1'b1);
    wr(2'b10, 16'hABCD, 1'b1);
    wait_for_en(8'h7F, ok);
    if (ok) wait_for_en(8'hFE, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_align: seg_en=%h required 7F then FE within bound", seg_en);
      return;
    end
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < int'(SD); c++) begin
        checks++;
        if (seg_en !== ~(8'h01 << d) || seg_out !== want[d]) begin
          errors++;
          $display("FAIL frame digit %0d cyc %0d: seg_en=%h seg_out=%h required %h %h",
                   d, c, seg_en, seg_out, ~(8'h01 << d), want[d]);
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_dp;
    int d;
    wr(2'b01, 16'hFF81, 1'b1);
    @(negedge clock);
    for (int i = 0; i < int'(8 * SD); i++) begin
      d = digit_of(seg_en);
      checks++;
      if (d < 0 || seg_out[7] !== !(d == 0 || d == 7) || seg_out !== exp_out || seg_en !== exp_en) begin
        errors++;
        $display("FAIL dp_mask cyc %0d: seg_en=%h seg_out=%h required %h %h",
                 i, seg_en, seg_out, exp_en, exp_out);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_ignored;
    logic [7:0] prev [8];
    int d;
    for (int i = 0; i < 8; i++) prev[i] = 8'hXX;
    for (int i = 0; i < int'(8 * SD); i++) begin
      d = digit_of(seg_en);
      if (d >= 0) prev[d] = seg_out;
      @(negedge clock);
    end
    wr(2'b11, 16'($urandom), 1'b1);
    wr(2'b00, 16'($urandom), 1'b0);
    wr(2'b10, 16'($urandom), 1'b0);
    wr(2'b01, 16'($urandom), 1'b0);
    segcs = 1'b1; segwrite = 1'b0; segaddr = 2'b00; segwdata = 16'hFFFF;
    @(negedge clock);
    segcs = 1'b0;
    for (int i = 0; i < int'(8 * SD); i++) begin
      d = digit_of(seg_en);
      checks++;
      if (d < 0 || seg_out !== prev[d] || seg_out !== exp_out) begin
        errors++;
        $display("FAIL ignored_write cyc %0d: seg_en=%h seg_out=%h required %h",
                 i, seg_en, seg_out, (d < 0) ? exp_out : prev[d]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_leading_zero;
    int d;
    logic [7:0] want;
    wr(2'b01, 16'h0000, 1'b1);
    wr(2'b10, 16'h0000, 1'b1);
    wr(2'b00, 16'h0F00, 1'b1);
    @(negedge clock);
    for (int i = 0; i < int'(8 * SD); i++) begin
      d = digit_of(seg_en);
      if (d == 2) want = 8'h8E;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      else if (d >= 3) want = 8'hFF;
`endif
      else want = 8'hC0;
      checks++;
      if (d < 0 || seg_out !== want || seg_out !== exp_out) begin
        errors++;
        $display("FAIL leading_zero digit %0d: seg_out=%h required %h", d, seg_out, want);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back;
    segcs = 1'b1; segwrite = 1'b1;
    segaddr = 2'b00; segwdata = 16'h5A6B;
    @(negedge clock);
    segaddr = 2'b10; segwdata = 16'h7C8D;
    @(negedge clock);
    segaddr = 2'b01; segwdata = 16'h0042;
    @(negedge clock);
    segcs = 1'b0; segwrite = 1'b0;
    for (int i = 0; i < int'(8 * SD); i++) begin
      checks++;
      if (seg_en !== exp_en || seg_out !== exp_out) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: seg_en=%h seg_out=%h required %h %h",
                 i, seg_en, seg_out, exp_en, exp_out);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      checks++;
      if (seg_en !== exp_en || seg_out !== exp_out) begin
        errors++;
        $display("FAIL random cyc %0d: seg_en=%h seg_out=%h required %h %h",
                 i, seg_en, seg_out, exp_en, exp_out);
      end
      segcs    = ($urandom_range(0, 3) != 0);
      segwrite = 1'($urandom_range(0, 1));
      segaddr  = 2'($urandom);
      segwdata = 16'($urandom) >> $urandom_range(0, 16);
      @(negedge clock);
    end
    segcs = 1'b0; segwrite = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    wr(2'b00, 16'h9876, 1'b1);
    wr(2'b01, 16'h00FF, 1'b1);
    wait_for_en(8'hDF, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_mid_align: seg_en=%h required DF within bound", seg_en);
      return;
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (seg_en !== 8'hFF || seg_out !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid_hold: seg_en=%h seg_out=%h required FF FF", seg_en, seg_out);
    end
    reset = 1'b1;
    for (int i = 0; i < int'(SD); i++) begin
      @(negedge clock);
      checks++;
      if (seg_en !== 8'hFE || seg_out !== 8'hC0) begin
        errors++;
        $display("FAIL reset_mid_restart[%0d]: seg_en=%h seg_out=%h required FE C0", i, seg_en, seg_out);
      end
    end
    @(negedge clock);
    checks++;
    if (seg_en !== 8'hFD || seg_out !== 8'hC0) begin
      errors++;
      $display("FAIL reset_mid_next: seg_en=%h seg_out=%h required FD C0", seg_en, seg_out);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_dp();
    test_ignored();
    test_leading_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
